// File: rtl/arm_instr_encoder.sv
// rtl/arm_instr_encoder.sv - field-level ARM request packer with output FIFO
module arm_instr_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [3:0]  in_cond,
  input  logic [5:0]  in_funct,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic [11:0] in_src2,
  input  logic [23:0] in_imm24,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [15:0] count
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_occ;
  logic          r_err;
  logic [15:0]   r_count;

  logic [3:0]    w_cmd;
  logic          w_s;
  logic          w_illegal;
  logic [31:0]   w_word;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  assign w_cmd = in_funct[4:1];
  assign w_s   = in_funct[0];

  // Pack the request fields and decide legality; legality covers every op.
  always_comb begin
    w_illegal = 1'b0;
    w_word    = 32'h0;
    if (in_cond == 4'b1111) begin
      w_illegal = 1'b1;
    end
    case (in_op)
      OP_DP: begin
        case (w_cmd)
          4'b0000, 4'b0010, 4'b0100, 4'b1100: begin
          end
          CMD_CMP: begin
            // a compare that does not set flags does nothing useful
            if (!w_s) w_illegal = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
        w_word = {in_cond, 2'b00, in_funct, in_rn,
                  (w_cmd == CMD_CMP) ? 4'b0000 : in_rd, in_src2};
      end
      OP_MEM: begin
        // funct = {~I, P, U, B, W, L}: post-index, writeback and byte forms unsupported
        if (!in_funct[4] || in_funct[1] || in_funct[2]) w_illegal = 1'b1;
        w_word = {in_cond, 2'b01, in_funct, in_rn, in_rd, in_src2};
      end
      OP_BR: begin
        w_word = {in_cond, 4'b1010, in_imm24};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign in_ready  = (r_occ != OCC_FULL);
  assign out_valid = (r_occ != '0);
  assign out_instr = out_valid ? r_mem[r_rptr] : 32'h0;
  assign err       = r_err;
  assign count     = r_count;

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && !w_illegal;
  assign w_pop    = out_valid && out_ready;

  // FIFO storage; contents need no reset because out_instr is gated by occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // Pointers, occupancy, error pulse and accepted-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_err   <= 1'b0;
      r_count <= 16'h0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_push) begin
        r_wptr  <= r_wptr + PTR_ONE;
        r_count <= r_count + 16'h1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_instr_encoder.sv
// tb/tb_arm_instr_encoder.sv - directed self-checking bench for arm_instr_encoder
module tb_arm_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [3:0]  in_cond;
  logic [5:0]  in_funct;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [11:0] in_src2;
  logic [23:0] in_imm24;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [15:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  arm_instr_encoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cond(in_cond), .in_funct(in_funct),
    .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_imm24(in_imm24),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] cond, input logic [5:0] funct,
                       input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] src2,
                       input logic [23:0] imm);
    in_op = op; in_cond = cond; in_funct = funct;
    in_rn = rn; in_rd = rd; in_src2 = src2; in_imm24 = imm;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] cond, input logic [5:0] funct,
                      input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] src2,
                      input logic [23:0] imm);
    drive(op, cond, funct, rn, rd, src2, imm);
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [3:0]  cmds [4];
  logic [31:0] w;
  logic [3:0]  c;
  logic [5:0]  f;
  logic        v, r, acc, pop;
  logic [15:0] m_count;

  initial begin
    cmds[0] = 4'b0000; cmds[1] = 4'b0010; cmds[2] = 4'b0100; cmds[3] = 4'b1100;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(2'b00, 4'b1110, 6'b101000, 4'd0, 4'd0, 12'h0, 24'h0);
    in_valid = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_count", {16'b0, count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b1;
    tick();

    // ADD R1,R2,#5 : not visible before the edge, visible right after
    drive(2'b00, 4'b1110, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0);
    #1;
    chk("add_not_same_cycle", {31'b0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_word", out_instr, 32'hE2821005);
    chk("add_count", {16'b0, count}, 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("add_drained", {31'b0, out_valid}, 32'd0);

    // STR then LDR, in order
    send(2'b01, 4'b1110, 6'b011000, 4'd4, 4'd3, 12'h008, 24'h0);
    send(2'b01, 4'b1110, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h0);
    chk("str_word", out_instr, 32'hE5843008);
    chk("str_held", out_instr, 32'hE5843008);
    out_ready = 1'b1; tick();
    chk("ldr_word", out_instr, 32'hE5943008);
    tick(); out_ready = 1'b0;
    chk("mem_drained", {31'b0, out_valid}, 32'd0);
    chk("mem_count", {16'b0, count}, 32'd3);

    // BEQ and CMP (rd forced to zero)
    send(2'b10, 4'b0000, 6'b000000, 4'd0, 4'd0, 12'h0, 24'h000003);
    send(2'b00, 4'b1110, 6'b110101, 4'd5, 4'd7, 12'h000, 24'h0);
    chk("beq_word", out_instr, 32'h0A000003);
    out_ready = 1'b1; tick();
    chk("cmp_word", out_instr, 32'hE3550000);
    tick(); out_ready = 1'b0;
    chk("br_count", {16'b0, count}, 32'd5);

    // four back-to-back illegal requests
    send(2'b11, 4'b1110, 6'b101000, 4'd1, 4'd1, 12'h0, 24'h0);
    chk("ill_op_err", {31'b0, err}, 32'd1);
    send(2'b00, 4'b1111, 6'b101000, 4'd1, 4'd1, 12'h0, 24'h0);
    chk("ill_cond_err", {31'b0, err}, 32'd1);
    send(2'b00, 4'b1110, 6'b110100, 4'd1, 4'd1, 12'h0, 24'h0);
    chk("ill_cmp_err", {31'b0, err}, 32'd1);
    send(2'b01, 4'b1110, 6'b001010, 4'd1, 4'd1, 12'h0, 24'h0);
    chk("ill_mem_err", {31'b0, err}, 32'd1);
    chk("ill_no_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("ill_err_clear", {31'b0, err}, 32'd0);
    chk("ill_count", {16'b0, count}, 32'd5);
    chk("ill_still_empty", {31'b0, out_valid}, 32'd0);

    // back-pressure: four fill the FIFO, the fifth waits
    for (int k = 1; k <= 4; k++) begin
      send(2'b00, 4'b1110, 6'b101000, 4'd2, 4'(k), 12'h005, 24'h0);
    end
    chk("bp_full", {31'b0, in_ready}, 32'd0);
    drive(2'b00, 4'b1110, 6'b101000, 4'd2, 4'd5, 12'h005, 24'h0);
    tick();
    chk("bp_wait_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_wait_count", {16'b0, count}, 32'd9);
    chk("bp_head1", out_instr, 32'hE2821005);
    out_ready = 1'b1; tick();
    chk("bp_after_pop_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_after_pop_count", {16'b0, count}, 32'd9);
    chk("bp_head2", out_instr, 32'hE2822005);
    tick(); in_valid = 1'b0;
    chk("bp_fifth_count", {16'b0, count}, 32'd10);
    chk("bp_head3", out_instr, 32'hE2823005);
    tick();
    chk("bp_head4", out_instr, 32'hE2824005);
    tick();
    chk("bp_head5", out_instr, 32'hE2825005);
    tick();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // mixed traffic against a queue model
    m_count = 16'd10;
    for (int i = 0; i < 320; i++) begin
      v = ($urandom_range(1) == 1);
      r = (i % 64 < 32) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      c = cmds[$urandom_range(3)];
      f = {1'($urandom_range(1)), c, 1'($urandom_range(1))};
      drive(2'b00, 4'($urandom_range(14)), f, 4'($urandom_range(15)), 4'($urandom_range(15)),
            12'($urandom_range(4095)), 24'h0);
      in_valid = v; out_ready = r;
      w = {in_cond, 2'b00, in_funct, in_rn, in_rd, in_src2};
      chk("rnd_ready", {31'b0, in_ready}, {31'b0, (q.size() < 4)});
      if (q.size() > 0) chk("rnd_head", out_instr, q[0]);
      else chk("rnd_empty", {31'b0, out_valid}, 32'd0);
      acc = v && (q.size() < 4);
      pop = r && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(w);
        m_count = m_count + 16'd1;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b0;
    chk("rnd_drained", {31'b0, out_valid}, 32'd0);
    chk("rnd_count", {16'b0, count}, {16'b0, m_count});

    // asynchronous reset with three words buffered
    for (int k = 1; k <= 3; k++) begin
      send(2'b01, 4'b1110, 6'b011000, 4'd4, 4'(k), 12'h008, 24'h0);
    end
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_count", {16'b0, count}, 32'd0);
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_empty", {31'b0, out_valid}, 32'd0);
    send(2'b10, 4'b0001, 6'b000000, 4'd0, 4'd0, 12'h0, 24'h123456);
    chk("post_rst_word", out_instr, 32'h1A123456);
    chk("post_rst_count", {16'b0, count}, 32'd1);
    out_ready = 1'b1; tick();
    chk("post_rst_only_one", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
